// File: rtl/instruction_memory_responder_pkg.sv
// instruction_memory_responder_pkg: instruction encoding constants and sizing helpers
//   Holds opcode values, payload width and an instruction builder shared by the
//   responder RTL and program-load tooling.
package instruction_memory_responder_pkg;
    localparam int OPCODE_WIDTH           = 3;
    localparam int INSTRUCTION_DATA_WIDTH = 13;
    localparam int INSTRUCTION_WIDTH      = OPCODE_WIDTH + INSTRUCTION_DATA_WIDTH;

    localparam logic [OPCODE_WIDTH-1:0] ACCEPT                = 3'd0;
    localparam logic [OPCODE_WIDTH-1:0] SPLIT                 = 3'd1;
    localparam logic [OPCODE_WIDTH-1:0] MATCH_CHARACTER       = 3'd2;
    localparam logic [OPCODE_WIDTH-1:0] NOT_MATCH_CHARACTER   = 3'd3;
    localparam logic [OPCODE_WIDTH-1:0] MATCH_ANY             = 3'd4;
    localparam logic [OPCODE_WIDTH-1:0] JUMP                  = 3'd5;
    localparam logic [OPCODE_WIDTH-1:0] END_WITHOUT_ACCEPTING = 3'd6;
    localparam logic [OPCODE_WIDTH-1:0] ACCEPT_PARTIAL        = 3'd7;

    function automatic logic [INSTRUCTION_WIDTH-1:0] make_instruction(
        input logic [OPCODE_WIDTH-1:0]           op,
        input logic [INSTRUCTION_DATA_WIDTH-1:0] data
    );
        return {op, data};
    endfunction

    // Grant index width; a single requester still needs a 1-bit index
    function automatic int id_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/instruction_memory_bram.sv
// instruction_memory_bram: simple dual-port RAM, one write port, one registered read port
//   i_clk                : clock
//   i_we/i_waddr/i_wdata : write port, committed at posedge
//   i_re/i_raddr         : read request, data appears on o_rdata one cycle later
//   o_rdata              : registered read data, held while i_re is low
module instruction_memory_bram #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);
    logic [WIDTH-1:0] r_mem [0:2**ADDR_WIDTH-1];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/instruction_memory_responder.sv
// instruction_memory_responder: round-robin instruction-fetch responder with host program load
//   i_clk          : clock
//   i_rst_n        : asynchronous active-low reset
//   i_memory_valid : per-CPU fetch request
//   i_memory_addr  : per-CPU fetch address, CPU i at slice i
//   o_memory_ready : per-CPU one-cycle grant pulse
//   o_memory_data  : per-CPU fetched word, held until that CPU's next response
//   i_load_valid/i_load_addr/i_load_data : program write, has priority over fetches
//   o_load_ready   : high whenever out of reset
module instruction_memory_responder
    import instruction_memory_responder_pkg::*;
#(
    parameter int N_CPU             = 2,
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic [N_CPU-1:0]                     i_memory_valid,
    input  logic [N_CPU*MEMORY_ADDR_WIDTH-1:0]   i_memory_addr,
    output logic [N_CPU-1:0]                     o_memory_ready,
    output logic [N_CPU*MEMORY_WIDTH-1:0]        o_memory_data,
    input  logic                                 i_load_valid,
    input  logic [MEMORY_ADDR_WIDTH-1:0]         i_load_addr,
    input  logic [MEMORY_WIDTH-1:0]              i_load_data,
    output logic                                 o_load_ready
);
    localparam int ID_W = id_width(N_CPU);

    logic [N_CPU-1:0]                   r_ready;
    logic [N_CPU-1:0][MEMORY_WIDTH-1:0] r_data;
    logic [ID_W-1:0]                    r_ptr;
    logic [N_CPU-1:0]                   w_eligible;
    logic                               w_grant;
    logic [ID_W-1:0]                    w_grant_id;
    logic [MEMORY_ADDR_WIDTH-1:0]       w_rd_addr;
    logic [MEMORY_WIDTH-1:0]            w_rd_data;

    // A CPU in its ready cycle still holds valid; mask it so it is not served twice
    assign w_eligible = i_memory_valid & ~r_ready;

    // Scan from the farthest offset down so the requester nearest the pointer wins
    always_comb begin
        w_grant    = 1'b0;
        w_grant_id = '0;
        for (int k = N_CPU - 1; k >= 0; k--) begin
            if (w_eligible[(int'(r_ptr) + k) % N_CPU]) begin
                w_grant    = 1'b1;
                w_grant_id = ID_W'((int'(r_ptr) + k) % N_CPU);
            end
        end
        if (i_load_valid) w_grant = 1'b0;
    end

    assign w_rd_addr = i_memory_addr[int'(w_grant_id)*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];

    instruction_memory_bram #(
        .WIDTH      (MEMORY_WIDTH),
        .ADDR_WIDTH (MEMORY_ADDR_WIDTH)
    ) u_bram (
        .i_clk   (i_clk),
        .i_we    (i_load_valid),
        .i_waddr (i_load_addr),
        .i_wdata (i_load_data),
        .i_re    (w_grant),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    // r_ready is both the stage-1 pipeline register and the ready output
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ready <= '0;
            r_data  <= '0;
            r_ptr   <= '0;
        end else begin
            r_ready <= w_grant ? N_CPU'(1) << w_grant_id : '0;
            if (w_grant) r_ptr <= (int'(w_grant_id) == N_CPU - 1) ? '0 : w_grant_id + 1'b1;
            for (int i = 0; i < N_CPU; i++)
                if (r_ready[i]) r_data[i] <= w_rd_data;
        end
    end

    assign o_memory_ready = r_ready;
    assign o_memory_data  = r_data;
    assign o_load_ready   = i_rst_n;
endmodule

// File: tb/tb_instruction_memory_responder.sv
// tb_instruction_memory_responder: directed and random checks against a transaction-level model
module tb_instruction_memory_responder;
    import instruction_memory_responder_pkg::*;

    localparam int N  = 2;
    localparam int W  = 16;
    localparam int AW = 11;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    valid;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    ready;
    logic [N*W-1:0]  data;
    logic            load_valid;
    logic [AW-1:0]   load_addr;
    logic [W-1:0]    load_data;
    logic            load_ready;

    int errors = 0;
    int checks = 0;

    // Model: RAM contents, round-robin pointer, previous grant, word fetched for it
    logic [W-1:0]   mmem [0:2**AW-1];
    int             m_ptr;
    int             m_prev;
    logic [W-1:0]   m_rword;
    logic [N-1:0]   m_ready;
    logic [N*W-1:0] m_data;

    always #5 clk = ~clk;

    instruction_memory_responder #(
        .N_CPU(N), .MEMORY_WIDTH(W), .MEMORY_ADDR_WIDTH(AW)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_memory_valid (valid),
        .i_memory_addr  (addr),
        .o_memory_ready (ready),
        .o_memory_data  (data),
        .i_load_valid   (load_valid),
        .i_load_addr    (load_addr),
        .i_load_data    (load_data),
        .o_load_ready   (load_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_prev  = -1;
        m_ready = '0;
        m_data  = '0;
    endtask

    // One clock edge: predict from current inputs, advance, then compare everything
    task automatic tick();
        int g = -1;
        if (m_prev >= 0) m_data[m_prev*W +: W] = m_rword;
        if (load_valid) mmem[load_addr] = load_data;
        else
            for (int k = 0; k < N; k++) begin
                int c = (m_ptr + k) % N;
                if (g < 0 && valid[c] && c != m_prev) g = c;
            end
        if (g >= 0) begin
            m_rword = mmem[addr[g*AW +: AW]];
            m_ptr   = (g + 1) % N;
        end
        m_prev  = g;
        m_ready = g >= 0 ? N'(1 << g) : '0;
        @(posedge clk);
        #1;
        chk("ready", 32'(ready), 32'(m_ready));
        chk("data", data, m_data);
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [W-1:0] d);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic set_req(input logic [N-1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        valid = v;
        addr  = {a1, a0};
    endtask

    logic [N-1:0] prev_ready;

    initial begin
        rst_n      = 1'b0;
        valid      = '0;
        addr       = '0;
        load_valid = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 32'(ready), 32'h0);
        chk("reset_data", data, 32'h0);
        chk("reset_load_ready", 32'(load_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("load_ready_high", 32'(load_ready), 32'h1);

        for (int a = 0; a < 16; a++) load(AW'(a), W'($urandom));
        load(11'd9, 16'h0000);
        load(11'h7FF, W'($urandom));

        // Load then fetch: one-cycle ready, masked while valid held
        load(11'd5, 16'h1234);
        set_req(2'b01, 11'd5, 11'd0);
        tick();
        chk("t1_ready_pulse", 32'(ready), 32'h1);
        tick();
        chk("t1_ready_masked", 32'(ready), 32'h0);
        chk("t1_data", 32'(data[15:0]), 32'h1234);
        set_req(2'b00, 11'd0, 11'd0);
        tick();

        // Same-cycle requests with pointer at 0
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        set_req(2'b11, 11'd3, 11'd7);
        tick();
        chk("t2_first_cpu0", 32'(ready), 32'h1);
        tick();
        chk("t2_then_cpu1", 32'(ready), 32'h2);
        chk("t2_cpu0_word", 32'(data[15:0]), 32'(mmem[3]));
        set_req(2'b00, 11'd0, 11'd0);
        tick();
        chk("t2_cpu1_word", 32'(data[31:16]), 32'(mmem[7]));
        chk("t2_cpu0_kept", 32'(data[15:0]), 32'(mmem[3]));

        // Continuous requests from both CPUs alternate
        set_req(2'b11, 11'd1, 11'd2);
        prev_ready = '0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("t3_one_grant", 32'($countones(ready)), 32'h1);
            chk("t3_no_repeat", 32'(ready & prev_ready), 32'h0);
            prev_ready = ready;
        end
        set_req(2'b00, 11'd0, 11'd0);
        tick();
        tick();

        // Load collides with a request to the same address
        set_req(2'b01, 11'd9, 11'd0);
        load_valid = 1'b1;
        load_addr  = 11'd9;
        load_data  = 16'hBEEF;
        tick();
        load_valid = 1'b0;
        chk("t4_no_grant", 32'(ready), 32'h0);
        tick();
        chk("t4_grant", 32'(ready), 32'h1);
        set_req(2'b00, 11'd0, 11'd0);
        tick();
        chk("t4_new_word", 32'(data[15:0]), 32'hBEEF);

        // Reset during CPU1's ready cycle
        set_req(2'b10, 11'd0, 11'd4);
        tick();
        chk("t5_ready1", 32'(ready), 32'h2);
        rst_n = 1'b0;
        #1;
        chk("t5_async_ready", 32'(ready), 32'h0);
        chk("t5_async_data", data, 32'h0);
        chk("t5_load_ready_low", 32'(load_ready), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t5_rerequest", 32'(ready), 32'h2);
        set_req(2'b00, 11'd0, 11'd0);
        tick();
        chk("t5_rerequest_word", 32'(data[31:16]), 32'(mmem[4]));

        // Top address, then address 0
        load(11'h7FF, make_instruction(END_WITHOUT_ACCEPTING, 13'h0ABC));
        set_req(2'b10, 11'd0, 11'h7FF);
        tick();
        set_req(2'b00, 11'd0, 11'd0);
        tick();
        chk("t6_end_word", 32'(data[31:16]), 32'(make_instruction(END_WITHOUT_ACCEPTING, 13'h0ABC)));
        set_req(2'b01, 11'h000, 11'd0);
        tick();
        set_req(2'b00, 11'd0, 11'd0);
        tick();
        chk("t6_addr0_word", 32'(data[15:0]), 32'(mmem[0]));

        // Random traffic over the preloaded region
        for (int c = 0; c < 400; c++) begin
            valid = N'($urandom);
            for (int i = 0; i < N; i++)
                addr[i*AW +: AW] = ($urandom_range(0, 9) == 0) ? 11'h7FF : AW'($urandom_range(0, 15));
            load_valid = ($urandom_range(0, 9) == 0);
            load_addr  = AW'($urandom_range(0, 15));
            load_data  = W'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
